// File: rtl/alu_pipe.sv
// alu_pipe -- pipelined integer ALU functional unit for the execute stage.
//
// Accepts one issued reservation-station entry per cycle, computes the
// add/sub/compare/logic result and the branch-taken flag combinationally at
// the input, and registers it into stage 0 of an elastic pipeline of STAGES
// register stages. Bubbles collapse: a beat moves forward whenever the next
// stage is empty or advancing. The head result is held until out_yumi.
// flush kills every in-flight beat and any beat presented in the same cycle.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             kill all in-flight ops and the beat presented this cycle
//   in_valid/in_ready issue handshake (in_ready depends combinationally on out_yumi)
//   in_op             4-bit opcode (ADD..XOR, 0xD-0xF illegal -> 0)
//   in_a, in_b        operands
//   in_tag            ROB tag travelling with the op
//   out_valid         result present at the pipeline head
//   out_yumi          consumer takes the head result this cycle
//   out_result        result value (a-b for branch ops)
//   out_tag           ROB tag of the head result
//   out_br_taken      branch condition (0 for non-branch ops)
//   occupancy         number of valid stages (registered)
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 3,
    parameter int STAGES = 2,
    parameter int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_yumi,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_br_taken,
    output logic [OCC_W-1:0] occupancy
);

    localparam int LAST = STAGES - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_SLT  = 4'h2,
        OP_SLTU = 4'h3,
        OP_BEQ  = 4'h4,
        OP_BNE  = 4'h5,
        OP_BLT  = 4'h6,
        OP_BGE  = 4'h7,
        OP_BLTU = 4'h8,
        OP_BGEU = 4'h9,
        OP_AND  = 4'hA,
        OP_OR   = 4'hB,
        OP_XOR  = 4'hC
    } op_e;

    // ------------------------------------------------------------------
    // Execute: one shared subtractor a + ~b + 1 feeds SUB, compares and
    // branch conditions.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   diff_full;
    logic [WIDTH-1:0] low_sum;
    logic [WIDTH-1:0] diff;
    logic             carry_out;
    logic             carry_msb;
    logic             is_zero;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] alu_res;
    logic             alu_br;

    assign diff_full = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH + 1)'(1);
    // Same sum over the low WIDTH-1 bits; its top bit is the carry into the MSB.
    assign low_sum   = {1'b0, in_a[WIDTH-2:0]} + {1'b0, ~in_b[WIDTH-2:0]} + WIDTH'(1);
    assign diff      = diff_full[WIDTH-1:0];
    assign carry_out = diff_full[WIDTH];
    assign carry_msb = low_sum[WIDTH-1];
    assign is_zero   = (diff == '0);
    assign lt_s      = diff[WIDTH-1] ^ (carry_msb ^ carry_out);
    assign lt_u      = ~carry_out;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alu_res = '0;
        alu_br  = 1'b0;
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = diff;
            OP_SLT:  alu_res = WIDTH'(lt_s);
            OP_SLTU: alu_res = WIDTH'(lt_u);
            OP_BEQ:  begin alu_res = diff; alu_br = is_zero;  end
            OP_BNE:  begin alu_res = diff; alu_br = ~is_zero; end
            OP_BLT:  begin alu_res = diff; alu_br = lt_s;     end
            OP_BGE:  begin alu_res = diff; alu_br = ~lt_s;    end
            OP_BLTU: begin alu_res = diff; alu_br = lt_u;     end
            OP_BGEU: begin alu_res = diff; alu_br = ~lt_u;    end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            default: begin alu_res = '0; alu_br = 1'b0; end
        endcase
    end

    // ------------------------------------------------------------------
    // Elastic pipeline control
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] advance;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [STAGES-1:0] br_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic              accept;

    // Walk from the head backwards: a stage advances when it holds a beat
    // and the stage ahead can load; a stage loads when empty or advancing.
    always_comb begin
        logic next_load;
        advance       = '0;
        load          = '0;
        advance[LAST] = valid_q[LAST] & out_yumi;
        load[LAST]    = ~valid_q[LAST] | advance[LAST];
        next_load     = load[LAST];
        for (int i = LAST - 1; i >= 0; i--) begin
            advance[i] = valid_q[i] & next_load;
            load[i]    = ~valid_q[i] | advance[i];
            next_load  = load[i];
        end
    end

    assign in_ready = load[0] & ~reset;
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        valid_d    = '0;
        occ_d      = '0;
        valid_d[0] = accept | (valid_q[0] & ~advance[0]);
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = advance[i-1] | (valid_q[i] & ~advance[i]);
        end
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // NOTE: data stages are cleared only by reset (so out_* read 0 afterwards); flush just drops the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
                tag_q[i] <= '0;
            end
            br_q <= '0;
        end else begin
            if (accept) begin
                res_q[0] <= alu_res;
                tag_q[0] <= in_tag;
                br_q[0]  <= alu_br;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (advance[i-1]) begin
                    res_q[i] <= res_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                    br_q[i]  <= br_q[i-1];
                end
            end
        end
    end

    assign out_valid    = valid_q[LAST];
    assign out_result   = res_q[LAST];
    assign out_tag      = tag_q[LAST];
    assign out_br_taken = br_q[LAST];
    assign occupancy    = occ_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU functional unit for the execute stage, successor to the single-cycle add/sub unit. It accepts one issued reservation-station entry per cycle (operands, opcode, ROB tag) and computes add/sub/compare/logic results plus branch-taken flags. Results flow through a configurable-depth elastic pipeline with per-stage bubble collapse, and are held until the common-data-bus arbiter accepts them. A flush kills every in-flight operation on a branch mispredict.

## Interface
- WIDTH, 32, operand/result width (>= 2)
- TAG_W, 3, ROB tag width
- STAGES, 2, pipeline depth in register stages (>= 1)
- OCC_W, $clog2(STAGES+1), width of occupancy count (derived, not overridden)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  kill all in-flight ops and any beat presented this cycle
- in_valid  input  1  issue beat present
- in_ready  output  1  unit can accept a beat this cycle
- in_op  input  4  opcode (see Operation)
- in_a, in_b  input  WIDTH  rs1, rs2 operand values
- in_tag  input  TAG_W  ROB entry of the op
- out_valid  output  1  result at head of pipeline
- out_yumi  input  1  consumer takes result this cycle; legal only when out_valid=1
- out_result  output  WIDTH  result value
- out_tag  output  TAG_W  ROB entry of result
- out_br_taken  output  1  branch condition true (0 for non-branch ops)
- occupancy  output  OCC_W  number of valid stages

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 SLT signed a<b -> 1/0; 3 SLTU unsigned a<b; 4 BEQ; 5 BNE; 6 BLT; 7 BGE; 8 BLTU; 9 BGEU; A AND; B OR; C XOR; D-F illegal -> result 0, br_taken 0.
- All arithmetic modulo 2^WIDTH. Compare via single subtractor a + ~b + 1: zero = (diff==0), signed lt = N xor V (V = carry into MSB xor carry out), unsigned lt = not carry-out.
- Branch ops (4-9): out_result = a-b, out_br_taken = condition. SLT/SLTU result zero-extended to WIDTH.
- Computation is combinational at input, registered into stage 0; stages 1..STAGES-1 carry result/tag/br_taken unchanged.
- Stage i (last = STAGES-1) loads when it is empty or its contents advance; last stage advances on out_yumi. Bubbles collapse: a beat moves forward whenever the next stage is empty or advancing.
- in_ready = (stage 0 empty or stage 0 advancing) and not reset. Accept = in_valid & in_ready & ~flush.
- flush: all stage valid bits cleared at the edge; flush wins over out_yumi and over accept. Data registers need not be cleared.
- occupancy = popcount of stage valid bits, registered state (updated in same edge as valids).

## Timing
- Reset: all valids 0; out_valid 0, out_result 0, out_tag 0, out_br_taken 0, occupancy 0; in_ready 0 while reset high, 1 the cycle after.
- Latency: beat accepted at edge k with empty pipeline shows out_valid=1 after edge k+STAGES-1 (STAGES=1: next cycle).
- Throughput: 1 op/cycle when out_yumi held high; in_ready stays 1 with full pipeline if out_yumi=1 (combinational ready path from out_yumi).
- Stall: out_valid=0 -> out_yumi ignored. With out_yumi=0, outputs held stable; pipeline fills until occupancy=STAGES then in_ready=0.
- Order preserved: results leave in acceptance order.
- Reset mid-operation: identical to reset from idle; no result emitted afterward.

## Test plan
- STAGES=2, ADD a=0xFFFFFFFF b=1 tag=5, out_yumi=1 -> out_valid 2 cycles later, result 0x00000000, tag 5, br_taken 0.
- SLT a=0x80000000 b=1 -> result 1; SLTU same operands -> 0; BLT a=0x7FFFFFFF b=0x80000000 -> br_taken 0, BGEU -> br_taken 0, BLTU -> 1.
- BEQ a=b=0x1234 -> br_taken 1, result 0; BNE same -> 0; opcode 0xE -> result 0, br_taken 0.
- Back-to-back 8 ADDs tags 0..7 with out_yumi=0: occupancy reaches 2, in_ready 0; release out_yumi -> tags emerge 0..7 in order, one per cycle, none lost/duplicated.
- Pipeline full, bubble pattern (valid in stage 1 only): new beat enters stage 0 and collapses forward next cycle; occupancy tracks exactly.
- flush asserted with occupancy 2 and in_valid=1, out_yumi=1 -> next cycle out_valid 0, occupancy 0, no result for any of the three tags; reset asserted mid-stream -> same, in_ready 0 during reset.
